// File: rtl/seq_mul32_pkg.sv
// Shared types and constants for the sequential 32x32 shift-add multiplier.
// The ZERO_SKIP_EN build option is consumed by seq_mul32, not by this package.
package mul_pkg;

    localparam int MUL_W    = 32;
    localparam int MUL_ITER = 32;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

endpackage

// File: rtl/seq_mul32_koggestone32bit.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
// Five prefix levels (spans 1,2,4,8,16) combine generate/propagate pairs.
module koggestone32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cIn,
    output logic [31:0] sum,
    output logic        cOut
);

    logic [31:0] p0;
    logic [31:0] g_pre;
    logic [31:0] p_pre;
    logic [31:0] g_nxt;
    logic [31:0] p_nxt;

    assign p0 = a ^ b;

    // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
    always_comb begin
        g_pre    = a & b;
        p_pre    = p0;
        g_pre[0] = (a[0] & b[0]) | (p0[0] & cIn);
        g_nxt    = g_pre;
        p_nxt    = p_pre;
        for (int lv = 0; lv < 5; lv++) begin
            g_nxt = g_pre;
            p_nxt = p_pre;
            for (int i = 0; i < 32; i++) begin
                if (i >= (1 << lv)) begin
                    g_nxt[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << lv)]);
                    p_nxt[i] = p_pre[i] & p_pre[i - (1 << lv)];
                end
            end
            g_pre = g_nxt;
            p_pre = p_nxt;
        end
    end

    assign sum  = p0 ^ {g_pre[30:0], cIn};
    assign cOut = g_pre[31];

endmodule

// File: rtl/seq_mul32.sv
// Sequential 32x32 unsigned shift-add multiplier, one partial-product add per clock.
// Build option ZERO_SKIP_EN: a zero operand skips the iterations and completes one edge after accept.
module seq_mul32
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output mul_state_t           state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid && ready; a/b are sampled only then,
    // and product stays stable from the first out_valid cycle until out_ready completes the transfer.

    if (WIDTH != MUL_W) begin : g_width_check
        $error("seq_mul32: WIDTH must be 32");
    end
    if ((1 << CNT_W) <= WIDTH) begin : g_cnt_check
        $error("seq_mul32: CNT_W too small to hold 0..WIDTH");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    mul_state_t           state;
    mul_state_t           state_nxt;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic                 accept;
    logic                 zero_op;

`ifdef ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    koggestone32bit u_add (
        .a    (hi),
        .b    (a_q),
        .cIn  (1'b0),
        .sum  (add_sum),
        .cOut (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            MUL_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = zero_op ? MUL_DONE : MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = MUL_DONE;
                end
            end
            MUL_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = MUL_IDLE;
                end
            end
            default: state_nxt = MUL_IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // The adder carry-out becomes the new HI msb, so the 33-bit partial sum is never truncated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
        end else begin
            if (accept) begin
                a_q <= a;
                hi  <= '0;
                lo  <= zero_op ? '0 : b;
                cnt <= '0;
            end else if (state == MUL_BUSY) begin
                if (lo[0]) begin
                    {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
                end else begin
                    {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
                end
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign product   = {hi, lo};
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_mul32.sv
// Directed bench for seq_mul32: reset abort, latency, carry path, back-pressure, back-to-back, zero operands.
// Expected latency for zero operands follows ZERO_SKIP_EN.
module tb_seq_mul32;
    import mul_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;
    mul_state_t  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    seq_mul32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef ZERO_SKIP_EN
        return ((x == 0) || (y == 0)) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    // driver: called at a negedge; returns at the negedge following the accept edge
    task automatic issue(input logic [31:0] ta, input logic [31:0] tbv, input bit keep_valid);
        int guard = 0;
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("accept_timeout", 64'(guard < 200), 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // counts edges from the accept edge (inclusive) until out_valid is seen
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [63:0] exp);
        int lat;
        issue(ta, tbv, 1'b0);
        wait_result(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(ta, tbv)));
        check({tag, "_prod"}, product, exp);
        drain();
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] held;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_state", 64'(state_dbg), 64'(MUL_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reset mid-BUSY, then 3*5
        issue(32'd3, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("t1_3x5", 32'd3, 32'd5, 64'd15);

        // 2: 3*5 with out_ready held high
        out_ready = 1'b1;
        issue(32'd3, 32'd5, 1'b0);
        check("t2_busy", 64'(busy), 64'd1);
        check("t2_in_ready_busy", 64'(in_ready), 64'd0);
        wait_result(lat);
        check("t2_lat", 64'(lat), 64'd33);
        check("t2_prod", product, 64'd15);
        @(negedge clk);
        check("t2_in_ready_next", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        // 3: carry-out path
        run_op("t3_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        // 4: msb times two, then 10 cycles of back-pressure
        issue(32'h8000_0000, 32'd2, 1'b0);
        wait_result(lat);
        check("t4_prod", product, 64'h0000_0001_0000_0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_prod", product, 64'h0000_0001_0000_0000);
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_in_ready", 64'(in_ready), 64'd0);
        end
        drain();

        // 5: back-to-back with in_valid held high
        issue(32'd7, 32'd6, 1'b1);
        a = 32'd9;
        b = 32'd9;
        wait_result(lat);
        check("t5_first_prod", product, 64'd42);
        repeat (2) @(negedge clk);
        check("t5_no_accept_done", 64'(in_ready), 64'd0);
        check("t5_state_done", 64'(state_dbg), 64'(MUL_DONE));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_idle_after_hs", 64'(state_dbg), 64'(MUL_IDLE));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_second_accepted", 64'(busy), 64'd1);
        lat = 1;
        wait_result(lat);
        check("t5_second_prod", product, 64'd81);
        drain();

        // 6: zero operand
        run_op("t6_0x123", 32'd0, 32'd123, 64'd0);
        run_op("t6_123x0", 32'd123, 32'd0, 64'd0);

        // out_ready before out_valid has no effect
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check("early_ready_idle", 64'(state_dbg), 64'(MUL_IDLE));

        // scoreboard over random operands with random back-pressure
        for (int n = 0; n < 120; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 40 == 5) ra = 32'd0;
            if (n % 40 == 6) rb = 32'hFFFF_FFFF;
            exp_q.push_back(64'(ra) * 64'(rb));
            issue(ra, rb, 1'b0);
            wait_result(lat);
            check("rnd_lat", 64'(lat), 64'(exp_lat(ra, rb)));
            held = product;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rnd_hold", product, held);
            end
            check("rnd_prod", product, exp_q.pop_front());
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_tests++;
        n_fail++;
        $display("FAIL global_timeout: observed running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
